ieu_ctrl: RTL and testbench

Multi-cycle sequencer for the integer execution unit. It steps each instruction through FETCH, DECODE, EXEC, MEM, WB and TRAP, and drives the datapath enables and select lines around the decode unit and ALU. It runs the request/acknowledge handshakes to instruction and data memory and applies a watchdog to each one. It also counts retired instructions.

---
 rtl/ieu_pkg.sv | 41 ++++
 rtl/ieu_watchdog.sv | 28 ++
 rtl/ieu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ieu_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieu_pkg.sv
// Shared encodings for the integer execution unit: opcodes, sequencer states
// and the datapath select codes driven by the sequencer.
package ieu_pkg;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_LUI      = 5'b01101;

   typedef enum logic [2:0] {
      StFetch, StDecode, StExec, StMem, StWb, StTrap
   } ieu_state_e;

   typedef enum logic [1:0] {
      PcPlus4 = 2'b00, PcAlu = 2'b01, PcTrap = 2'b10
   } pc_sel_e;

   typedef enum logic [1:0] {
      WselAlu = 2'b00, WselLoad = 2'b01, WselPc4 = 2'b10
   } rf_wsel_e;

   typedef enum logic [1:0] {
      CauseIllegal = 2'b00, CauseFetchTo = 2'b01, CauseDmemErr = 2'b10, CauseDmemTo = 2'b11
   } trap_cause_e;

   function automatic logic opcode_legal(input logic [4:0] op);
      case (op)
         OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_MISC_MEM, OPC_JAL,
         OPC_OP_IMM, OPC_OP, OPC_SYSTEM, OPC_AUIPC, OPC_LUI: return 1'b1;
         default:                                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ieu_watchdog.sv
// Request watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT-1.
module ieu_watchdog #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT);

   logic [CntW-1:0] cnt_q;

   assign expired = (cnt_q == CntW'(TIMEOUT - 1));

   // Holds at the limit; the sequencer always leaves the state and clears it.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/ieu_ctrl.sv
// Multi-cycle sequencer for the integer execution unit: walks each instruction
// through fetch/decode/exec/mem/wb, runs memory handshakes and traps.
module ieu_ctrl
   import ieu_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          opcode,
   input  logic [1:0]          instr_low,
   input  logic [2:0]          funct3,
   input  logic                branch_taken,
   output logic                imem_req,
   input  logic                imem_ack,
   output logic                ir_we,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ack,
   input  logic                dmem_err,
   output logic                mdr_we,
   output logic                alu_latch,
   output logic                pc_we,
   output logic [1:0]          pc_sel,
   output logic                rf_we,
   output logic [1:0]          rf_wsel,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic                retire,
   output logic [RETIRE_W-1:0] retire_cnt
);

   ieu_state_e          state_q, state_d;
   trap_cause_e         cause_q, cause_d;
   logic                active_q;
   logic [RETIRE_W-1:0] cnt_q;
   logic                wd_expired, wd_clr, wd_en;
   logic                is_load, is_store;
   logic                unused_funct3;

   assign unused_funct3 = ^funct3;
   assign is_load       = (opcode == OPC_LOAD);
   assign is_store      = (opcode == OPC_STORE);

   // active_q keeps every output low for the cycle after reset was sampled.
   assign wd_en  = active_q && (state_q == StFetch || state_q == StMem);
   assign wd_clr = !active_q || (state_d != state_q);

   ieu_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (wd_clr),
      .en     (wd_en),
      .expired(wd_expired)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      if (active_q) begin
         case (state_q)
            StFetch: begin
               if (imem_ack) begin
                  state_d = StDecode;
               end else if (wd_expired) begin
                  state_d = StTrap;
                  cause_d = CauseFetchTo;
               end
            end
            StDecode: begin
               if (instr_low != 2'b11 || !opcode_legal(opcode)) begin
                  state_d = StTrap;
                  cause_d = CauseIllegal;
               end else begin
                  state_d = StExec;
               end
            end
            StExec: state_d = (is_load || is_store) ? StMem : StWb;
            StMem: begin
               if (dmem_err) begin
                  state_d = StTrap;
                  cause_d = CauseDmemErr;
               end else if (dmem_ack) begin
                  state_d = StWb;
               end else if (wd_expired) begin
                  state_d = StTrap;
                  cause_d = CauseDmemTo;
               end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StFetch;
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StFetch;
         cause_q  <= CauseIllegal;
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         active_q <= 1'b1;
         if (active_q && state_q == StWb) begin
            cnt_q <= cnt_q + RETIRE_W'(1);
         end
      end
   end

   always_comb begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      mdr_we    = 1'b0;
      alu_latch = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PcPlus4;
      rf_we     = 1'b0;
      rf_wsel   = WselAlu;
      trap      = 1'b0;
      retire    = 1'b0;
      if (active_q) begin
         case (state_q)
            StFetch: begin
               imem_req = 1'b1;
               ir_we    = imem_ack;
            end
            StExec: alu_latch = 1'b1;
            StMem: begin
               dmem_req = 1'b1;
               dmem_we  = is_store;
               mdr_we   = dmem_ack && !dmem_err && is_load;
            end
            StWb: begin
               pc_we  = 1'b1;
               retire = 1'b1;
               case (opcode)
                  OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: rf_we = 1'b1;
                  OPC_LOAD: begin
                     rf_we   = 1'b1;
                     rf_wsel = WselLoad;
                  end
                  OPC_JAL, OPC_JALR: begin
                     rf_we   = 1'b1;
                     rf_wsel = WselPc4;
                     pc_sel  = PcAlu;
                  end
                  OPC_BRANCH: pc_sel = branch_taken ? PcAlu : PcPlus4;
                  default: ;
               endcase
            end
            StTrap: begin
               trap   = 1'b1;
               pc_we  = 1'b1;
               pc_sel = PcTrap;
            end
            default: ;
         endcase
      end
   end

   assign trap_cause = cause_q;
   assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ieu_ctrl.sv
// Directed bench for ieu_ctrl with a short watchdog and a narrow retire
// counter so timeout and wrap-around are reachable quickly.
module tb_ieu_ctrl;
   import ieu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] opcode = '0;
   logic [1:0] instr_low = 2'b11;
   logic [2:0] funct3 = '0;
   logic       branch_taken = 1'b0;
   logic       imem_ack = 1'b0;
   logic       dmem_ack = 1'b0;
   logic       dmem_err = 1'b0;
   logic       imem_req, ir_we, dmem_req, dmem_we, mdr_we, alu_latch, pc_we;
   logic       rf_we, trap, retire;
   logic [1:0] pc_sel, rf_wsel, trap_cause;
   logic [3:0] retire_cnt;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [3:0] exp_cnt = '0;

   ieu_ctrl #(
      .TIMEOUT (4),
      .RETIRE_W(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .instr_low   (instr_low),
      .funct3      (funct3),
      .branch_taken(branch_taken),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .ir_we       (ir_we),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ack    (dmem_ack),
      .dmem_err    (dmem_err),
      .mdr_we      (mdr_we),
      .alu_latch   (alu_latch),
      .pc_we       (pc_we),
      .pc_sel      (pc_sel),
      .rf_we       (rf_we),
      .rf_wsel     (rf_wsel),
      .trap        (trap),
      .trap_cause  (trap_cause),
      .retire      (retire),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, want finish before 100000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      branch_taken = 1'b0;
      step();
      settle();
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_pc_we", 32'(pc_we), 32'd0);
      check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
      check("rst_trap_cause", 32'(trap_cause), 32'd0);
      rst = 1'b0;
      exp_cnt = '0;
      step();
   endtask

   // Entered one tick after a posedge in FETCH; leaves in DECODE.
   task automatic fetch(input logic [4:0] op, input logic [1:0] low, input int nwait);
      for (int i = 0; i < nwait; i++) begin
         imem_ack = 1'b0;
         settle();
         check("fetch_wait_req", 32'(imem_req), 32'd1);
         check("fetch_wait_ir_we", 32'(ir_we), 32'd0);
         step();
      end
      imem_ack = 1'b1;
      opcode = op;
      instr_low = low;
      settle();
      check("fetch_ack_ir_we", 32'(ir_we), 32'd1);
      step();
      imem_ack = 1'b0;
   endtask

   task automatic decode_exec();
      settle();
      check("decode_imem_req", 32'(imem_req), 32'd0);
      step();
      settle();
      check("exec_alu_latch", 32'(alu_latch), 32'd1);
      step();
   endtask

   task automatic wb_check(input string tag, input logic rf, input logic [1:0] wsel,
                           input logic [1:0] psel);
      settle();
      check({tag, "_pc_we"}, 32'(pc_we), 32'd1);
      check({tag, "_retire"}, 32'(retire), 32'd1);
      check({tag, "_rf_we"}, 32'(rf_we), 32'(rf));
      if (rf) check({tag, "_rf_wsel"}, 32'(rf_wsel), 32'(wsel));
      check({tag, "_pc_sel"}, 32'(pc_sel), 32'(psel));
      step();
      exp_cnt = exp_cnt + 4'd1;
      check({tag, "_retire_cnt"}, 32'(retire_cnt), 32'(exp_cnt));
   endtask

   task automatic trap_check(input string tag, input logic [1:0] cause);
      settle();
      check({tag, "_trap"}, 32'(trap), 32'd1);
      check({tag, "_cause"}, 32'(trap_cause), 32'(cause));
      check({tag, "_pc_sel"}, 32'(pc_sel), 32'd2);
      check({tag, "_pc_we"}, 32'(pc_we), 32'd1);
      check({tag, "_no_retire"}, 32'(retire), 32'd0);
      check({tag, "_no_rf_we"}, 32'(rf_we), 32'd0);
      check({tag, "_req_low"}, 32'(imem_req | dmem_req), 32'd0);
      step();
      check({tag, "_cnt_kept"}, 32'(retire_cnt), 32'(exp_cnt));
   endtask

   initial begin
      do_reset();

      // ALU op, fetch ack two cycles after the request: count visible in cycle 7.
      fetch(OPC_OP, 2'b11, 2);
      decode_exec();
      settle();
      check("add_cnt_in_wb", 32'(retire_cnt), 32'd0);
      wb_check("add", 1'b1, 2'd0, 2'd0);
      settle();
      check("add_refetch", 32'(imem_req), 32'd1);

      // Zero-wait load.
      fetch(OPC_LOAD, 2'b11, 0);
      decode_exec();
      dmem_ack = 1'b1;
      settle();
      check("lw_dmem_req", 32'(dmem_req), 32'd1);
      check("lw_dmem_we", 32'(dmem_we), 32'd0);
      check("lw_mdr_we", 32'(mdr_we), 32'd1);
      step();
      dmem_ack = 1'b0;
      wb_check("lw", 1'b1, 2'd1, 2'd0);

      // Store: write enable on the bus, no load-data latch.
      fetch(OPC_STORE, 2'b11, 0);
      decode_exec();
      dmem_ack = 1'b1;
      settle();
      check("sw_dmem_we", 32'(dmem_we), 32'd1);
      check("sw_mdr_we", 32'(mdr_we), 32'd0);
      step();
      dmem_ack = 1'b0;
      wb_check("sw", 1'b0, 2'd0, 2'd0);

      // Branches taken and not taken, then a jump.
      fetch(OPC_BRANCH, 2'b11, 0);
      decode_exec();
      branch_taken = 1'b1;
      wb_check("beq_t", 1'b0, 2'd0, 2'd1);
      branch_taken = 1'b0;
      fetch(OPC_BRANCH, 2'b11, 0);
      decode_exec();
      wb_check("beq_nt", 1'b0, 2'd0, 2'd0);
      fetch(OPC_JAL, 2'b11, 0);
      decode_exec();
      wb_check("jal", 1'b1, 2'd2, 2'd1);

      // Fetch never acked: request held exactly four cycles.
      for (int i = 0; i < 4; i++) begin
         settle();
         check("ito_req_held", 32'(imem_req), 32'd1);
         step();
      end
      trap_check("ito", 2'd1);

      // Illegal opcode, then illegal low bits.
      fetch(5'b11111, 2'b11, 0);
      settle();
      step();
      trap_check("ill_op", 2'd0);
      fetch(OPC_OP, 2'b01, 0);
      settle();
      step();
      trap_check("ill_low", 2'd0);

      // Data memory never acks.
      fetch(OPC_LOAD, 2'b11, 0);
      decode_exec();
      for (int i = 0; i < 4; i++) begin
         settle();
         check("dto_req_held", 32'(dmem_req), 32'd1);
         step();
      end
      trap_check("dto", 2'd3);

      // Error and ack together on a load: error wins.
      fetch(OPC_LOAD, 2'b11, 0);
      decode_exec();
      dmem_ack = 1'b1;
      dmem_err = 1'b1;
      settle();
      check("err_mdr_we", 32'(mdr_we), 32'd0);
      step();
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      trap_check("err", 2'd2);

      // Fetch ack in the expiry cycle completes normally.
      fetch(OPC_OP, 2'b11, 3);
      decode_exec();
      wb_check("late_ack", 1'b1, 2'd0, 2'd0);

      // Reset during MEM, with a stray ack afterwards.
      fetch(OPC_LOAD, 2'b11, 0);
      decode_exec();
      settle();
      check("mrst_req_before", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      dmem_ack = 1'b1;
      step();
      settle();
      check("mrst_dmem_req", 32'(dmem_req), 32'd0);
      check("mrst_imem_req", 32'(imem_req), 32'd0);
      check("mrst_mdr_we", 32'(mdr_we), 32'd0);
      check("mrst_retire_cnt", 32'(retire_cnt), 32'd0);
      check("mrst_trap_cause", 32'(trap_cause), 32'd0);
      rst = 1'b0;
      exp_cnt = '0;
      step();
      settle();
      check("stray_imem_req", 32'(imem_req), 32'd1);
      check("stray_dmem_req", 32'(dmem_req), 32'd0);
      check("stray_mdr_we", 32'(mdr_we), 32'd0);
      dmem_ack = 1'b0;

      // Sixteen retires wrap the 4-bit counter back to zero.
      for (int i = 0; i < 16; i++) begin
         fetch(OPC_OP_IMM, 2'b11, 0);
         decode_exec();
         wb_check("wrap", 1'b1, 2'd0, 2'd0);
      end
      check("wrap_zero", 32'(retire_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
